// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus port arbiter slice.
package bus_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // Ceiling log2, used for grant index and counter widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_port_arbiter_rr.sv
// Combinational round-robin picker: first request after last_grant, wrapping.
module rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [clog2(N_REQ)-1:0] last_grant,
    output logic [N_REQ-1:0]        grant_onehot,
    output logic [clog2(N_REQ)-1:0] grant_idx
);

    localparam int GW  = clog2(N_REQ);
    localparam int GW1 = GW + 1;
    localparam logic [GW:0] N_LIM = GW1'(N_REQ);

    logic [GW:0] start;
    logic [GW:0] cand;
    logic        found;

    // Walk the requests starting one past the last winner, modulo N_REQ.
    always_comb begin
        start = GW1'(last_grant) + GW1'(1);
        if (start >= N_LIM) begin
            start = '0;
        end
        cand      = '0;
        found     = 1'b0;
        grant_idx = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = start + GW1'(off);
            if (cand >= N_LIM) begin
                cand = cand - N_LIM;
            end
            if (!found && req[cand[GW-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[GW-1:0];
            end
        end
        grant_onehot = found ? (N_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/bus_port_arbiter.sv
// Shares one bus master port between N_REQ requesters, one transaction at a time.
module bus_port_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int N_REQ       = 2,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0]             req_mode,
    input  logic [N_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [N_REQ-1:0]             req_accept,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         d_valid,
    output logic                         d_mode,
    output logic [ADDR_WIDTH-1:0]        d_addr,
    output logic [DATA_WIDTH-1:0]        d_wdata,
    input  logic [DATA_WIDTH-1:0]        d_rdata,
    input  logic                         d_ready,
    input  logic                         s_ready,
    output logic                         busy,
    output logic [clog2(N_REQ)-1:0]      grant_id
);

    localparam int GW = clog2(N_REQ);
    localparam int CW = clog2(ACK_TIMEOUT) + 1;
    // The ISSUE cycle is the first cycle of the ack window, so WAIT_ACK
    // gives up when the count including the current cycle reaches this.
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);

    state_t                  state;
    state_t                  state_next;
    logic [GW-1:0]           last_grant;
    logic [GW-1:0]           arb_idx;
    logic [N_REQ-1:0]        arb_onehot;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_inc;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    sel_mode;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr (
        .req         (req_valid),
        .last_grant  (last_grant),
        .grant_onehot(arb_onehot),
        .grant_idx   (arb_idx)
    );

    assign cnt_inc = cnt + CW'(1);

    // Pick the winning requester's mode, address and write data.
    always_comb begin
        sel_mode  = MODE_READ;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_onehot[i]) begin
                sel_mode  = req_mode[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state decode and per-state outputs; unknown encodings act as IDLE.
    always_comb begin
        state_next = state;
        d_valid    = 1'b0;
        req_accept = '0;
        rsp_valid  = '0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (d_ready && s_ready && (req_valid != '0)) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                d_valid    = 1'b1;
                req_accept = N_REQ'(1) << grant_id;
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!d_ready) begin
                    state_next = WAIT_DONE;
                end else if (cnt_inc >= ACK_LAST) begin
                    state_next = RESP;
                end
            end
            WAIT_DONE: begin
                if (d_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid  = N_REQ'(1) << grant_id;
                rsp_rdata  = rdata_q;
                rsp_err    = err_q;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // State register plus the grant, latched request, counter and response data.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(N_REQ - 1);
            d_mode     <= 1'b0;
            d_addr     <= '0;
            d_wdata    <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (state_next == ISSUE) begin
                        grant_id <= arb_idx;
                        d_mode   <= sel_mode;
                        d_addr   <= sel_addr;
                        d_wdata  <= sel_wdata;
                    end
                end
                ISSUE: begin
                    cnt     <= '0;
                    rdata_q <= '0;
                end
                WAIT_ACK: begin
                    cnt <= cnt_inc;
                    if (d_ready && (cnt_inc >= ACK_LAST)) begin
                        err_q <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (d_ready) begin
                        rdata_q <= (d_mode == MODE_WRITE) ? '0 : d_rdata;
                    end
                end
                RESP: begin
                    last_grant <= grant_id;
                    err_q      <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
